serial_word_collector: RTL and testbench
========================================

// Module: serial_word_collector
// PURPOSE
//  Downstream stage of the parameterized shift register: consumes its serial output (SO) bit stream and reassembles W-bit words.
//  Bit counter, accumulator, output holding register with valid/ready handshake, overrun detection.
//  Output words feed the parallel consumer (register file or the data input of a next shift register).
// PARAMETERS
//  W          4        word width in bits; legal range W >= 2
//  FIRST_BIT  "msb"    "msb": first received bit lands in word[W-1] (pairs with left-shifting source); "lsb": first bit lands in word[0]
//  CW         $clog2(W+1)  localparam, bit_count width
// PORTS
//  clk         in   1   clock, rising edge
//  aclr        in   1   reset, asynchronous, active-high
//  sclr        in   1   synchronous clear, active-high
//  bit_valid   in   1   bit_in is valid this cycle
//  bit_in      in   1   serial data bit
//  word_data   out  W   assembled word, registered
//  word_valid  out  1   word_data holds an unconsumed word
//  word_ready  in   1   consumer accepts word_data when word_valid=1
//  overrun     out  1   sticky: one or more bits were dropped
//  bit_count   out  CW  bits held in accumulator, 0..W
// BEHAVIOUR
//  Reset (aclr, or sclr at edge): word_data=0, word_valid=0, overrun=0, bit_count=0, accumulator=0, state=COLLECT. Priority: aclr > sclr > normal operation.
//  States: COLLECT (accumulating), STALL (accumulator full, output register occupied).
//  Handshake: word transfers on the edge where word_valid & word_ready; word_valid holds and word_data is stable until then.
//  COLLECT, bit_valid=1: the bit is accepted.
//    msb: acc <= {acc[W-2:0],bit_in}; lsb: acc <= {bit_in,acc[W-1:1]}; bit_count+1.
//    Accepted bit is the Wth and the output is free (word_valid=0, or word_ready=1 this cycle): word_data <= completed word with bypass including bit_in, word_valid <= 1, bit_count <= 0.
//      Latency: word_valid is high in the cycle right after the edge that accepted the last bit.
//    Accepted bit is the Wth and the output is occupied: bit_count <= W, go to STALL.
//  COLLECT, bit_valid=0: hold. A pending consume still clears word_valid.
//  STALL, word_valid & word_ready: word_data <= acc, word_valid stays 1, bit_count <= 0, go to COLLECT.
//    If bit_valid=1 on that same edge, the bit is accepted as bit 1 of the next word (bit_count=1).
//  STALL, no consume: hold. bit_valid=1 drops the bit and sets overrun.
//  overrun clears only on aclr/sclr.
//  bit_count never exceeds W. No wrap-around: a counter wrap from W to 0 happens only on transfer.
//  bit_valid is ignored in a cycle where sclr=1.
//  aclr mid-word discards the partial word. After release, the next W accepted bits form a fresh word.
//  word_ready while word_valid=0 has no effect.
// STRUCTURE
//  shared package shift_stage_pkg: state encodings (ST_COLLECT=1'b0, ST_STALL=1'b1) and direction string constants ("msb"/"lsb", "left"/"right"), shared with the shift register.
//  One sub-module: swc_bit_counter. Holds bit_count, with inc/clr/load-W controls and a last-bit compare (count==W-1).
//  Accumulator, output register and FSM live in the top level.
// TESTING
//  W=4 msb: bits 1,0,1,1 on 4 consecutive cycles, word_ready=1 -> word_valid=1 the next cycle with word_data=4'b1011, then 0.
//  W=4 lsb: same bits -> word_data=4'b1101; bit_count steps 1,2,3,0.
//  Backpressure: word_ready=0, send 1011 then 0110 -> STALL with bit_count=4 and word_data stays 1011.
//    A 9th bit is dropped and overrun=1.
//    Then word_ready=1 for one cycle -> word_data=0110, word_valid stays 1.
//  Simultaneous events: in STALL, word_ready=1 and bit_valid=1 (bit=1) on the same edge -> word_data=0110, bit_count=1, the next 3 bits complete the following word.
//  aclr pulse after 2 bits of a word -> all outputs 0 immediately. Then bits 0,0,1,1 -> word_data=4'b0011.
//  sclr=1 together with bit_valid=1, overrun=1 -> next cycle overrun=0, bit_count=0, word_valid=0, the bit is not counted.

Source files
------------

// File: rtl/shift_stage_pkg.sv
// Shared definitions for the shift-register stage family: FSM state encoding and
// direction/bit-order name constants used as string parameters.
package shift_stage_pkg;

   typedef enum logic [0:0] {
      ST_COLLECT = 1'b0,
      ST_STALL   = 1'b1
   } stage_state_t;

   localparam string DIR_MSB   = "msb";
   localparam string DIR_LSB   = "lsb";
   localparam string DIR_LEFT  = "left";
   localparam string DIR_RIGHT = "right";

endpackage

// File: rtl/swc_bit_counter.sv
// Accumulator fill counter for serial_word_collector: counts accepted bits 0..W,
// with clear, increment and load-full controls plus a last-bit flag.
module swc_bit_counter #(
   parameter int W  = 4,
   parameter int CW = $clog2(W + 1)
) (
   input  logic          clk,
   input  logic          aclr,
   input  logic          sclr,
   input  logic          inc,
   input  logic          clr,
   input  logic          load_full,
   output logic [CW-1:0] count,
   output logic          last_bit
);

   logic [CW-1:0] count_next;

   // clr and inc on the same edge yield 1: the word transfers and the new bit starts the next one
   always_comb begin
      count_next = count;
      if (sclr) begin
         count_next = '0;
      end else if (load_full) begin
         count_next = CW'(W);
      end else if (clr) begin
         count_next = inc ? CW'(1) : '0;
      end else if (inc) begin
         count_next = count + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
         count <= '0;
      end else begin
         count <= count_next;
      end
   end

   assign last_bit = (count == CW'(W - 1));

endmodule

// File: rtl/serial_word_collector.sv
// Reassembles W-bit words from a serial bit stream, with a valid/ready output
// register, a one-word stall buffer in the accumulator and sticky overrun.
module serial_word_collector
   import shift_stage_pkg::*;
#(
   parameter int    W         = 4,
   parameter string FIRST_BIT = DIR_MSB,
   localparam int   CW        = $clog2(W + 1)
) (
   input  logic          clk,
   input  logic          aclr,
   input  logic          sclr,
   input  logic          bit_valid,
   input  logic          bit_in,
   output logic [W-1:0]  word_data,
   output logic          word_valid,
   input  logic          word_ready,
   output logic          overrun,
   output logic [CW-1:0] bit_count
);

   localparam bit LsbFirst = (FIRST_BIT == DIR_LSB);

   stage_state_t state;
   logic [W-1:0] acc;
   logic [W-1:0] acc_shift;
   logic         consume;
   logic         out_free;
   logic         last_bit;
   logic         cnt_inc;
   logic         cnt_clr;
   logic         cnt_full;

   assign acc_shift = LsbFirst ? {bit_in, acc[W-1:1]} : {acc[W-2:0], bit_in};
   assign consume   = word_valid & word_ready;
   assign out_free  = ~word_valid | word_ready;

   always_comb begin
      cnt_inc  = 1'b0;
      cnt_clr  = 1'b0;
      cnt_full = 1'b0;
      if (!sclr) begin
         unique case (state)
            ST_COLLECT: begin
               if (bit_valid) begin
                  if (!last_bit) begin
                     cnt_inc = 1'b1;
                  end else if (out_free) begin
                     cnt_clr = 1'b1;
                  end else begin
                     cnt_full = 1'b1;
                  end
               end
            end
            ST_STALL: begin
               if (consume) begin
                  cnt_clr = 1'b1;
                  cnt_inc = bit_valid;
               end
            end
         endcase
      end
   end

   swc_bit_counter #(
      .W  (W),
      .CW (CW)
   ) u_bit_counter (
      .clk       (clk),
      .aclr      (aclr),
      .sclr      (sclr),
      .inc       (cnt_inc),
      .clr       (cnt_clr),
      .load_full (cnt_full),
      .count     (bit_count),
      .last_bit  (last_bit)
   );

   always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
         state      <= ST_COLLECT;
         acc        <= '0;
         word_data  <= '0;
         word_valid <= 1'b0;
         overrun    <= 1'b0;
      end else if (sclr) begin
         state      <= ST_COLLECT;
         acc        <= '0;
         word_data  <= '0;
         word_valid <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         unique case (state)
            ST_COLLECT: begin
               if (consume) begin
                  word_valid <= 1'b0;
               end
               if (bit_valid) begin
                  acc <= acc_shift;
                  if (last_bit) begin
                     // Bypass: the completing bit goes straight into the output word
                     if (out_free) begin
                        word_data  <= acc_shift;
                        word_valid <= 1'b1;
                     end else begin
                        state <= ST_STALL;
                     end
                  end
               end
            end
            ST_STALL: begin
               if (consume) begin
                  word_data <= acc;
                  state     <= ST_COLLECT;
                  // Stale bits of the old word are shifted out by the next W-1 bits
                  if (bit_valid) begin
                     acc <= acc_shift;
                  end
               end else if (bit_valid) begin
                  overrun <= 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_word_collector.sv
// Bench for serial_word_collector: msb and lsb instances share stimulus and are
// checked every cycle against a queue-based reference model.
module tb_serial_word_collector;

   localparam int W  = 4;
   localparam int CW = $clog2(W + 1);

   logic          clk = 1'b0;
   logic          aclr = 1'b0;
   logic          sclr = 1'b0;
   logic          bit_valid = 1'b0;
   logic          bit_in = 1'b0;
   logic          word_ready = 1'b0;
   logic [W-1:0]  m_data, l_data;
   logic          m_valid, l_valid;
   logic          m_ovr, l_ovr;
   logic [CW-1:0] m_cnt, l_cnt;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: bits of the word being collected, plus the output slot
   bit            q[$];
   logic [W-1:0]  ref_msb = '0;
   logic [W-1:0]  ref_lsb = '0;
   bit            ref_valid = 1'b0;
   bit            ref_ovr = 1'b0;

   always #5 clk = ~clk;

   serial_word_collector #(.W(W), .FIRST_BIT("msb")) dut_msb (
      .clk        (clk),
      .aclr       (aclr),
      .sclr       (sclr),
      .bit_valid  (bit_valid),
      .bit_in     (bit_in),
      .word_data  (m_data),
      .word_valid (m_valid),
      .word_ready (word_ready),
      .overrun    (m_ovr),
      .bit_count  (m_cnt)
   );

   serial_word_collector #(.W(W), .FIRST_BIT("lsb")) dut_lsb (
      .clk        (clk),
      .aclr       (aclr),
      .sclr       (sclr),
      .bit_valid  (bit_valid),
      .bit_in     (bit_in),
      .word_data  (l_data),
      .word_valid (l_valid),
      .word_ready (word_ready),
      .overrun    (l_ovr),
      .bit_count  (l_cnt)
   );

   task automatic check(input string tag, input int obs, input int exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      q.delete();
      ref_msb   = '0;
      ref_lsb   = '0;
      ref_valid = 1'b0;
      ref_ovr   = 1'b0;
   endtask

   task automatic publish();
      for (int i = 0; i < W; i++) begin
         ref_msb[W-1-i] = q[i];
         ref_lsb[i]     = q[i];
      end
      q.delete();
      ref_valid = 1'b1;
   endtask

   task automatic model_edge(input bit s, input bit bv, input bit b, input bit rdy);
      bit take;
      if (s) begin
         model_clear();
         return;
      end
      take = ref_valid && rdy;
      if (q.size() == W) begin
         if (take) begin
            publish();
            if (bv) q.push_back(b);
         end else if (bv) begin
            ref_ovr = 1'b1;
         end
      end else begin
         if (take) ref_valid = 1'b0;
         if (bv) begin
            q.push_back(b);
            if (q.size() == W && !ref_valid) publish();
         end
      end
   endtask

   task automatic check_all();
      check("msb_valid", 32'(m_valid), 32'(ref_valid));
      check("msb_data", 32'(m_data), 32'(ref_msb));
      check("msb_overrun", 32'(m_ovr), 32'(ref_ovr));
      check("msb_count", 32'(m_cnt), q.size());
      check("lsb_valid", 32'(l_valid), 32'(ref_valid));
      check("lsb_data", 32'(l_data), 32'(ref_lsb));
      check("lsb_overrun", 32'(l_ovr), 32'(ref_ovr));
      check("lsb_count", 32'(l_cnt), q.size());
   endtask

   task automatic step(input bit s, input bit bv, input bit b, input bit rdy);
      sclr       = s;
      bit_valid  = bv;
      bit_in     = b;
      word_ready = rdy;
      @(posedge clk);
      model_edge(s, bv, b, rdy);
      #1;
      check_all();
   endtask

   task automatic pulse_aclr();
      aclr = 1'b1;
      model_clear();
      #1;
      check_all();
      @(negedge clk);
      aclr = 1'b0;
   endtask

   task automatic send_word(input logic [W-1:0] w, input bit rdy);
      logic [W-1:0] v;
      v = w;
      for (int i = W - 1; i >= 0; i--) step(1'b0, 1'b1, v[i], rdy);
   endtask

   initial begin
      aclr = 1'b1;
      #2;
      model_clear();
      check_all();
      @(negedge clk);
      aclr = 1'b0;
      step(1'b0, 1'b0, 1'b0, 1'b0);

      // Basic assembly: bits 1,0,1,1 with ready held high
      send_word(4'b1011, 1'b1);
      check("msb_word_1011", 32'(m_data), 32'hB);
      check("lsb_word_1101", 32'(l_data), 32'hD);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      check("consumed_valid", 32'(m_valid), 0);

      // Backpressure into STALL, dropped 9th bit, then consume with a bit on the same edge
      send_word(4'b1011, 1'b0);
      send_word(4'b0110, 1'b0);
      check("stall_count", 32'(m_cnt), W);
      check("stall_hold_data", 32'(m_data), 32'hB);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      check("overrun_set", 32'(m_ovr), 1);
      step(1'b0, 1'b1, 1'b1, 1'b1);
      check("stall_release_data", 32'(m_data), 32'h6);
      check("stall_release_cnt", 32'(m_cnt), 1);
      step(1'b0, 1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      check("next_word_1010", 32'(m_data), 32'hA);
      step(1'b0, 1'b0, 1'b0, 1'b1);

      // aclr mid-word discards the partial word
      step(1'b0, 1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b1, 1'b1);
      pulse_aclr();
      send_word(4'b0011, 1'b1);
      check("after_aclr_0011", 32'(m_data), 32'h3);

      // sclr with a simultaneous bit clears overrun and ignores the bit
      send_word(4'b1111, 1'b0);
      send_word(4'b0101, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      check("sclr_overrun", 32'(m_ovr), 0);
      check("sclr_count", 32'(m_cnt), 0);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 59) == 0) begin
            pulse_aclr();
         end else begin
            step($urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0,
                 1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
